// File: rtl/cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx
// Source-domain half of a req/ack clock-domain-crossing handshake. A word is
// accepted from local logic over valid/ready, held on o_data for the whole
// handshake, and announced to the destination domain through o_req. The
// asynchronous acknowledge i_ack is brought into i_clk through an internal
// ff_synchronizer. o_data only changes while o_req is idle, so the receiver
// can sample it directly once its synchronized view of o_req has changed.
//
// Build option:
//   CDC_HS_TX_TWO_PHASE_EN  undefined -> four-phase (return-to-zero) protocol
//                           defined   -> two-phase (toggle) protocol
//
// Parameters:
//   G_DATA_WIDTH  width of the transferred word
//   G_STAGES      depth of the i_ack synchronizer, must be >= 2
//
// Ports:
//   i_clk    source-domain clock
//   i_rst    synchronous active-high reset
//   i_valid  local logic offers i_data
//   o_ready  block can accept a word (FSM idle)
//   i_data   word to transfer
//   o_req    registered request to the destination domain
//   o_data   registered word, stable from accept until o_done
//   i_ack    asynchronous acknowledge from the destination domain
//   o_done   one-cycle pulse when the handshake completes
// -----------------------------------------------------------------------------

// Plain flip-flop chain synchronizer. Output lags the input by G_STAGES edges.
module ff_synchronizer #(
   parameter int G_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [G_STAGES-1:0] sync_reg;

   genvar gi;
   generate
      for (gi = 0; gi < G_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge i_clk) begin
               if (i_rst) sync_reg[gi] <= 1'b0;
               else       sync_reg[gi] <= i_d;
            end
         end else begin : g_rest
            always_ff @(posedge i_clk) begin
               if (i_rst) sync_reg[gi] <= 1'b0;
               else       sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign o_q = sync_reg[G_STAGES-1];

endmodule

module cdc_handshake_tx #(
   parameter int G_DATA_WIDTH = 8,
   parameter int G_STAGES     = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [G_DATA_WIDTH-1:0] i_data,
   output logic                    o_req,
   output logic [G_DATA_WIDTH-1:0] o_data,
   input  logic                    i_ack,
   output logic                    o_done
);

`ifdef CDC_HS_TX_TWO_PHASE_EN
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_ACK_LOW = 2'd2
   } state_t;
`endif

   state_t                  state_reg, state_next;
   logic                    req_reg, req_next;
   logic                    done_reg, done_next;
   logic [G_DATA_WIDTH-1:0] data_reg;
   logic                    ack_s;
   logic                    accept;

   ff_synchronizer #(
      .G_STAGES (G_STAGES)
   ) u_ack_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_ack),
      .o_q   (ack_s)
   );

   // Ready is decoded from the state register only, so there is no
   // combinational path from any input to o_ready.
   assign accept = i_valid && (state_reg == ST_IDLE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= ST_IDLE;
         req_reg   <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         req_reg   <= req_next;
         done_reg  <= done_next;
      end
   end

   // The word is captured only on accept; it is the quasi-static bus the
   // destination samples, so it must not move during the handshake.
   always_ff @(posedge i_clk) begin
      if (i_rst)       data_reg <= '0;
      else if (accept) data_reg <= i_data;
   end

   always_comb begin
      state_next = state_reg;
      req_next   = req_reg;
      done_next  = 1'b0;
`ifdef CDC_HS_TX_TWO_PHASE_EN
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               req_next   = ~req_reg;
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // The destination echoes the request level once it has the word.
            if (ack_s == req_reg) begin
               done_next  = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
`else
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               req_next   = 1'b1;
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            // Only the awaited level matters; ack activity in other
            // phases is deliberately ignored.
            if (ack_s) begin
               req_next   = 1'b0;
               state_next = ST_ACK_LOW;
            end
         end
         ST_ACK_LOW: begin
            if (!ack_s) begin
               done_next  = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            req_next   = 1'b0;
            state_next = ST_IDLE;
         end
      endcase
`endif
   end

   assign o_ready = (state_reg == ST_IDLE);
   assign o_req   = req_reg;
   assign o_data  = data_reg;
   assign o_done  = done_reg;

endmodule
